// File: rtl/video_timing_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_sequencer
// Description : Video raster timing generator. Paces a pixel stream into
//               encoder data/control words, realigning on start-of-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_sequencer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [23:0] pix_data,
    output logic        pix_ready,
    output logic        vde,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [1:0]  cd_blue,
    output logic [1:0]  cd_green,
    output logic [1:0]  cd_red,
    output logic [9:0]  hcount,
    output logic [9:0]  vcount,
    output logic        underflow,
    output logic        resync
);

    localparam int          c_ht       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_vt       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  c_h_last   = 10'(c_ht - 1);
    localparam logic [9:0]  c_v_last   = 10'(c_vt - 1);
    // 11-bit bounds so a sync region ending exactly at 1024 does not wrap
    localparam logic [10:0] c_h_active = 11'(H_ACTIVE);
    localparam logic [10:0] c_v_active = 11'(V_ACTIVE);
    localparam logic [10:0] c_hs_start = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_vs_start = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_vs_end   = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_sync_wait = 2'd1;
    localparam logic [1:0] c_st_run       = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [9:0]  r_h;
    logic [9:0]  r_v;
    logic        r_en_d;
    logic        r_vde;
    logic [23:0] r_rgb;
    logic [1:0]  r_cd_blue;
    logic [9:0]  r_hcount;
    logic [9:0]  r_vcount;
    logic        r_underflow;
    logic        r_resync;

    logic        w_at_origin;
    logic        w_active;
    logic        w_hs_on;
    logic        w_vs_on;
    logic        w_consume;
    logic        w_vde_nxt;
    logic        w_underflow_evt;
    logic        w_resync_evt;
    logic        w_blank;

    assign w_at_origin = (r_h == 10'd0) && (r_v == 10'd0);
    assign w_active    = ({1'b0, r_h} < c_h_active) && ({1'b0, r_v} < c_v_active);
    assign w_hs_on     = ({1'b0, r_h} >= c_hs_start) && ({1'b0, r_h} < c_hs_end);
    assign w_vs_on     = ({1'b0, r_v} >= c_vs_start) && ({1'b0, r_v} < c_vs_end);
    assign w_consume   = pix_valid && pix_ready;
    assign w_blank     = !enable || (r_state == c_st_idle);
    // Frame misalignment: sof away from the origin, or a plain pixel at it
    assign w_resync_evt = enable && (r_state == c_st_run) && w_consume
                          && (pix_sof != w_at_origin);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:      w_state_nxt = c_st_sync_wait;
                c_st_sync_wait: if (w_consume && pix_sof) w_state_nxt = c_st_run;
                c_st_run:       if (w_resync_evt) w_state_nxt = c_st_sync_wait;
                default:        w_state_nxt = c_st_idle;
            endcase
        end
    end

    // While waiting, non-sof pixels are drained; a sof pixel is held until the origin
    always_comb begin
        pix_ready       = 1'b0;
        w_vde_nxt       = 1'b0;
        w_underflow_evt = 1'b0;
        if (enable) begin
            case (r_state)
                c_st_sync_wait: begin
                    pix_ready = pix_valid && (!pix_sof || w_at_origin);
                    w_vde_nxt = pix_valid && pix_sof && w_at_origin && w_active;
                end
                c_st_run: begin
                    pix_ready       = w_active;
                    w_vde_nxt       = w_active;
                    w_underflow_evt = w_active && !pix_valid;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_h <= 10'd0;
            r_v <= 10'd0;
        end else if (w_blank) begin
            r_h <= 10'd0;
            r_v <= 10'd0;
        end else if (r_h == c_h_last) begin
            r_h <= 10'd0;
            r_v <= (r_v == c_v_last) ? 10'd0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_vde     <= 1'b0;
            r_rgb     <= 24'd0;
            r_cd_blue <= {~VS_POL, ~HS_POL};
            r_hcount  <= 10'd0;
            r_vcount  <= 10'd0;
        end else if (w_blank) begin
            r_vde     <= 1'b0;
            r_rgb     <= 24'd0;
            r_cd_blue <= {~VS_POL, ~HS_POL};
            r_hcount  <= 10'd0;
            r_vcount  <= 10'd0;
        end else begin
            r_vde     <= w_vde_nxt;
            r_rgb     <= (w_vde_nxt && w_consume) ? pix_data : 24'd0;
            r_cd_blue <= {(w_vs_on ? VS_POL : ~VS_POL), (w_hs_on ? HS_POL : ~HS_POL)};
            r_hcount  <= r_h;
            r_vcount  <= r_v;
        end
    end

    // Flags are cleared when a new run is requested
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_en_d      <= 1'b0;
            r_underflow <= 1'b0;
            r_resync    <= 1'b0;
        end else begin
            r_en_d <= enable;
            if (enable && !r_en_d) begin
                r_underflow <= 1'b0;
                r_resync    <= 1'b0;
            end else begin
                if (w_underflow_evt) r_underflow <= 1'b1;
                if (w_resync_evt)    r_resync    <= 1'b1;
            end
        end
    end

    assign vde       = r_vde;
    assign red       = r_rgb[23:16];
    assign green     = r_rgb[15:8];
    assign blue      = r_rgb[7:0];
    assign cd_blue   = r_cd_blue;
    assign cd_green  = 2'b00;
    assign cd_red    = 2'b00;
    assign hcount    = r_hcount;
    assign vcount    = r_vcount;
    assign underflow = r_underflow;
    assign resync    = r_resync;

endmodule
`default_nettype wire

// File: doc/video_timing_sequencer.md
VIDEO_TIMING_SEQUENCER -- requirements
Module: video_timing_sequencer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical porch and sync widths in lines.
REQ-005 SHALL have parameters HS_POL, VS_POL, default 0, asserted sync level (0 = active-low).
REQ-006 clk  input  1  pixel clock; all logic on rising edge.
REQ-007 resetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-008 enable  input  1  run request; low forces IDLE.
REQ-009 pix_valid  input  1  pixel source has a pixel.
REQ-010 pix_sof  input  1  qualifies pix_data as first pixel of a frame.
REQ-011 pix_data  input  24  {R[7:0],G[7:0],B[7:0]}.
REQ-012 pix_ready  output  1  pixel consumed this cycle when pix_valid&pix_ready.
REQ-013 vde  output  1  video data enable to all three encoders.
REQ-014 red, green, blue  output  8 each  encoder video data.
REQ-015 cd_blue  output  2  {vsync,hsync} control data to blue encoder.
REQ-016 cd_green, cd_red  output  2 each  control data, constant 2'b00.
REQ-017 hcount, vcount  output  10 each  registered counter position of current output.
REQ-018 underflow, resync  output  1 each  sticky error flags.

Function
REQ-019 SHALL count h 0..HT-1, HT=H_ACTIVE+H_FP+H_SYNC+H_BP; v increments when h wraps, wraps at VT-1, VT=V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-020 SHALL define active = h<H_ACTIVE && v<V_ACTIVE; hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync asserted for lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, full lines.
REQ-021 SHALL register all outputs except pix_ready; latency counter position -> outputs exactly 1 clock.
REQ-022 SHALL implement states IDLE, SYNC_WAIT, RUN.
REQ-023 IDLE: counters held at (0,0), vde=0, RGB=0, syncs deasserted, pix_ready=0; enable=1 -> SYNC_WAIT, counters start at (0,0) same cycle.
REQ-024 SYNC_WAIT: timing runs, vde=0; pix_ready=pix_valid&~pix_sof (discard stale pixels); at (0,0) with pix_valid&pix_sof, consume pixel, emit it, enter RUN.
REQ-025 RUN: pix_ready=active; vde=active registered; RGB=pix_data when consumed.
REQ-026 RUN, active, pix_valid=0: SHALL output vde=1, RGB=0, set underflow; timing never stalls.
REQ-027 RUN, consumed pixel has pix_sof=1 at position other than (0,0), or pixel at (0,0) lacks pix_sof: SHALL set resync, output that pixel, enter SYNC_WAIT next cycle.
REQ-028 enable=0 in any state SHALL enter IDLE next clock; outputs blank from that clock; mid-frame abort allowed.
REQ-029 Outside active, RGB SHALL be 0 and pix_ready=0 in RUN.
REQ-030 Sticky flags SHALL clear only on reset or enable rising edge.
REQ-031 Counters SHALL use 10-bit unsigned arithmetic; HT and VT shall not exceed 1024.

Reset
REQ-032 resetn low SHALL asynchronously force IDLE, counters 0, vde=0, RGB=0, cd_blue={~VS_POL,~HS_POL}, flags 0.
REQ-033 Release SHALL be synchronous to clk; first state evaluation on first rising edge with resetn high.

Verification
REQ-034 Enable, source always valid, sof on first pixel of every frame -> vde high 640 clocks per line, 480 lines; hsync low h 656..751; vsync low lines 490..491; no flags.
REQ-035 Enable while source sends 5 non-sof pixels then sof -> 5 pixels dropped, first vde pixel equals sof pixel at (0,0), state RUN.
REQ-036 RUN, pix_valid low for 3 clocks at (100,10) -> vde=1, RGB=0 for those 3 outputs, underflow=1 persists.
REQ-037 RUN, sof pixel presented at (320,200) -> resync=1, SYNC_WAIT, vde=0 until next (0,0) with sof.
REQ-038 enable dropped at (400,300) -> next output vde=0, syncs inactive, counters (0,0); re-enable clears flags.
REQ-039 resetn asserted mid-line without clock edge -> outputs reach reset values immediately.
